// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath widths and word/index types shared by decoder, ALU and register file.
// Pure declarations; no logic, no latency, no backpressure.
package cpu_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int NUM_REGS   = 8;
   localparam int ADDR_WIDTH = 3;

   typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: NUM_REGS:1 combinational read mux; REG_FILE_BYPASS_EN adds write forwarding.
// Zero latency, no backpressure; out-of-range selects return 0.
module regfile_read_port #(
   parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
   parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
   input  logic [ADDR_WIDTH-1:0]               read_reg,
`ifdef REG_FILE_BYPASS_EN
   input  logic                                rst,
   input  logic                                reg_write,
   input  logic [ADDR_WIDTH-1:0]               write_reg,
   input  logic [DATA_WIDTH-1:0]               write_data,
`endif
   output logic [DATA_WIDTH-1:0]               read_data
);

   always_comb begin
      read_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (read_reg == ADDR_WIDTH'(i)) read_data = regs[i];
      end
`ifdef REG_FILE_BYPASS_EN
      // An out-of-range write is dropped, so it must not be forwarded either.
      if (!rst && reg_write && (read_reg == write_reg) && (int'(write_reg) < NUM_REGS))
         read_data = write_data;
`endif
   end

endmodule

// File: rtl/register_file.sv
// register_file: NUM_REGS x DATA_WIDTH registers, one synchronous write port, two combinational reads.
// Write visible after the edge, reads 0-cycle, no backpressure; define REG_FILE_BYPASS_EN for forwarding.
module register_file #(
   parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
   parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reg_write,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

   // Reset wins over a same-edge write; indices beyond NUM_REGS match no register.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '0;
      end else if (reg_write) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (write_reg == ADDR_WIDTH'(i)) regs[i] <= write_data;
         end
      end
   end

   regfile_read_port #(
      .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)
   ) u_read_port1 (
      .regs      (regs),
      .read_reg  (read_reg1),
`ifdef REG_FILE_BYPASS_EN
      .rst       (rst),
      .reg_write (reg_write),
      .write_reg (write_reg),
      .write_data(write_data),
`endif
      .read_data (read_data1)
   );

   regfile_read_port #(
      .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)
   ) u_read_port2 (
      .regs      (regs),
      .read_reg  (read_reg2),
`ifdef REG_FILE_BYPASS_EN
      .rst       (rst),
      .reg_write (reg_write),
      .write_reg (write_reg),
      .write_data(write_data),
`endif
      .read_data (read_data2)
   );

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file; expected values are hand-computed.
module tb_register_file;
   import cpu_pkg::*;

   logic     clk = 1'b0;
   logic     rst, reg_write;
   reg_idx_t write_reg, read_reg1, read_reg2;
   data_t    write_data, read_data1, read_data2;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic     rst;
      logic     we;
      reg_idx_t wr;
      data_t    wd;
      reg_idx_t r1;
      reg_idx_t r2;
      data_t    e1;
      data_t    e2;
   } vec_t;

   vec_t vecs[$];

   register_file dut (
      .clk       (clk),
      .rst       (rst),
      .reg_write (reg_write),
      .write_reg (write_reg),
      .write_data(write_data),
      .read_reg1 (read_reg1),
      .read_reg2 (read_reg2),
      .read_data1(read_data1),
      .read_data2(read_data2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input data_t act, input data_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic we, input int wr, input int wd,
                               input int r1, input int r2, input int e1, input int e2);
      vec_t v;
      v.rst = r;
      v.we  = we;
      v.wr  = reg_idx_t'(wr);
      v.wd  = data_t'(wd);
      v.r1  = reg_idx_t'(r1);
      v.r2  = reg_idx_t'(r2);
      v.e1  = data_t'(e1);
      v.e2  = data_t'(e2);
      vecs.push_back(v);
   endfunction

   initial begin
      rst = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
      read_reg1 = '0; read_reg2 = '0;

      // Each vector: drive at negedge, one rising edge, check outputs 1 time unit later.
      add(1, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00);          // reset
      for (int i = 0; i < 8; i++)
         add(0, 0, 0, 8'h00, i, 7 - i, 8'h00, 8'h00);   // all zero after reset
      add(0, 1, 6, 8'hFA, 6, 6, 8'hFA, 8'hFA);          // write R6
      add(0, 0, 0, 8'h00, 6, 5, 8'hFA, 8'h00);
      add(0, 0, 0, 8'h00, 0, 7, 8'h00, 8'h00);
      add(0, 0, 3, 8'h55, 3, 3, 8'h00, 8'h00);          // write disabled
      for (int i = 0; i < 8; i++)                       // fill R0..R7 = 0x10..0x17
         add(0, 1, i, 8'h10 + i, i, 6, 8'h10 + i, (i >= 6) ? 8'h16 : 8'hFA);
      add(0, 0, 0, 8'h00, 2, 7, 8'h12, 8'h17);
      add(0, 0, 0, 8'h00, 7, 2, 8'h17, 8'h12);
      add(0, 1, 4, 8'h11, 4, 0, 8'h11, 8'h10);          // prepare R4 = 0x11

      foreach (vecs[k]) begin
         @(negedge clk);
         rst = vecs[k].rst; reg_write = vecs[k].we; write_reg = vecs[k].wr;
         write_data = vecs[k].wd; read_reg1 = vecs[k].r1; read_reg2 = vecs[k].r2;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_rd1", k), read_data1, vecs[k].e1);
         check($sformatf("vec%0d_rd2", k), read_data2, vecs[k].e2);
      end

      // Same-cycle read and write of R4.
      @(negedge clk);
      rst = 1'b0; reg_write = 1'b1; write_reg = 3'd4; write_data = 8'hAB;
      read_reg1 = 3'd4; read_reg2 = 3'd3;
      #1;
`ifdef REG_FILE_BYPASS_EN
      check("rw_same_pre_edge", read_data1, 8'hAB);
`else
      check("rw_same_pre_edge", read_data1, 8'h11);
`endif
      check("rw_other_pre_edge", read_data2, 8'h13);
      @(posedge clk);
      #1;
      check("rw_same_post_edge", read_data1, 8'hAB);
      @(negedge clk);
      reg_write = 1'b0;
      #1;
      check("rw_same_held", read_data1, 8'hAB);

      // Reset together with a write to R5: stored value before the edge, zero after.
      @(negedge clk);
      rst = 1'b1; reg_write = 1'b1; write_reg = 3'd5; write_data = 8'hCC;
      read_reg1 = 3'd5; read_reg2 = 3'd4;
      #1;
      check("rst_wr_pre_edge", read_data1, 8'h15);
      @(posedge clk);
      #1;
      check("rst_wr_r5", read_data1, 8'h00);
      @(negedge clk);
      rst = 1'b0; reg_write = 1'b0;
      for (int i = 0; i < 8; i++) begin
         read_reg1 = reg_idx_t'(i);
         read_reg2 = reg_idx_t'(7 - i);
         #1;
         check($sformatf("post_rst_r%0d_p1", i), read_data1, 8'h00);
         check($sformatf("post_rst_r%0d_p2", 7 - i), read_data2, 8'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
